// File: rtl/peri_timer.sv
// peri_timer: bus-slot timer with a prescaler, a 32-bit up-counter, compare match, auto-reload and a level IRQ.
// Define PERI_TIMER_CAPTURE_EN to add the synchronized i_capture input and the CAPTURE register.
module peri_timer #(
    parameter int unsigned PRESCALE_W  = 16,
    parameter logic [31:0] COMPARE_RST = 32'hFFFF_FFFF
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_addr,
    input  logic        i_wren,
    input  logic        i_rden,
    input  logic [31:0] i_wdata,
    input  logic [3:0]  i_wstrb,
    output logic        o_ready,
    output logic [31:0] o_rdata,
    output logic        o_irq
`ifdef PERI_TIMER_CAPTURE_EN
    ,
    input  logic        i_capture
`endif
);

    typedef enum logic [2:0] {
        REG_CTRL     = 3'd0,
        REG_PRESCALE = 3'd1,
        REG_COUNT    = 3'd2,
        REG_COMPARE  = 3'd3,
        REG_STATUS   = 3'd4,
        REG_CAPTURE  = 3'd5,
        REG_RSVD6    = 3'd6,
        REG_RSVD7    = 3'd7
    } reg_idx_e;

    reg_idx_e              idx;
    logic [2:0]            ctrl;      // {IRQ_EN, AUTO_RELOAD, EN}
    logic [PRESCALE_W-1:0] prescale;
    logic [PRESCALE_W-1:0] pcnt;
    logic [31:0]           count;
    logic [31:0]           compare;
    logic                  st_match;
    logic                  st_capt;
    logic [31:0]           capture;
    logic [31:0]           pre_ext;
    logic [31:0]           rd_val;
    logic                  tick;
    logic                  hit;
    logic                  clr_status;
    logic                  unused_addr;

    function automatic logic [31:0] bmask(input logic [31:0] cur, input logic [31:0] wd,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = cur;
        for (int unsigned b = 0; b < 4; b++) begin
            if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
        end
        return r;
    endfunction

    assign idx         = reg_idx_e'(i_addr[4:2]);
    assign unused_addr = ^{i_addr[31:5], i_addr[1:0]};
    assign tick        = ctrl[0] && (pcnt == prescale);
    assign hit         = tick && (count == compare);
    assign clr_status  = i_wren && (idx == REG_STATUS) && i_wstrb[0];
    assign o_irq       = st_match & ctrl[2];

    always_comb begin
        pre_ext                 = '0;
        pre_ext[PRESCALE_W-1:0] = prescale;
    end

    always_comb begin
        rd_val = '0;
        case (idx)
            REG_CTRL:     rd_val[2:0] = ctrl;
            REG_PRESCALE: rd_val      = pre_ext;
            REG_COUNT:    rd_val      = count;
            REG_COMPARE:  rd_val      = compare;
            REG_STATUS:   rd_val[1:0] = {st_capt, st_match};
            REG_CAPTURE:  rd_val      = capture;
            default:      rd_val      = '0;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_ready  <= 1'b0;
            o_rdata  <= '0;
            ctrl     <= '0;
            prescale <= '0;
            pcnt     <= '0;
            count    <= '0;
            compare  <= COMPARE_RST;
            st_match <= 1'b0;
        end else begin
            o_ready <= i_rden | i_wren;
            o_rdata <= i_rden ? rd_val : '0;

            if (i_wren && (idx == REG_CTRL) && i_wstrb[0]) ctrl <= i_wdata[2:0];

            if (i_wren && (idx == REG_PRESCALE)) begin
                prescale <= PRESCALE_W'(bmask(pre_ext, i_wdata, i_wstrb));
                pcnt     <= '0;
            end else if (ctrl[0]) begin
                pcnt <= tick ? '0 : pcnt + PRESCALE_W'(1);
            end

            // A software write in a tick cycle overrides (and drops) the increment.
            if (i_wren && (idx == REG_COUNT)) count <= bmask(count, i_wdata, i_wstrb);
            else if (tick) count <= (hit && ctrl[1]) ? '0 : count + 32'd1;

            if (i_wren && (idx == REG_COMPARE)) compare <= bmask(compare, i_wdata, i_wstrb);

            if (hit) st_match <= 1'b1;
            else if (clr_status && i_wdata[0]) st_match <= 1'b0;
        end
    end

`ifdef PERI_TIMER_CAPTURE_EN
    logic [2:0] cap_sync;   // [1:0] synchronizer, [2] previous synchronized level
    logic       cap_edge;

    assign cap_edge = cap_sync[1] & ~cap_sync[2];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cap_sync <= '0;
            capture  <= '0;
            st_capt  <= 1'b0;
        end else begin
            cap_sync <= {cap_sync[1:0], i_capture};
            if (cap_edge) begin
                capture <= count;
                st_capt <= 1'b1;
            end else if (clr_status && i_wdata[1]) begin
                st_capt <= 1'b0;
            end
        end
    end
`else
    assign capture = '0;
    assign st_capt = 1'b0;
`endif

endmodule

// File: tb/tb_peri_timer.sv
// Directed self-checking bench for peri_timer: register access, prescaled counting, match/IRQ, wrap and reset.
// Capture checks are compiled in when PERI_TIMER_CAPTURE_EN is defined.
module tb_peri_timer;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr;
    logic        wren;
    logic        rden;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        ready;
    logic [31:0] rdata;
    logic        irq;
`ifdef PERI_TIMER_CAPTURE_EN
    logic        capture_in;
`endif

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    always #5 clk = ~clk;

    peri_timer #(
        .PRESCALE_W (16),
        .COMPARE_RST(32'hFFFF_FFFF)
    ) dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_addr   (addr),
        .i_wren   (wren),
        .i_rden   (rden),
        .i_wdata  (wdata),
        .i_wstrb  (wstrb),
        .o_ready  (ready),
        .o_rdata  (rdata),
        .o_irq    (irq)
`ifdef PERI_TIMER_CAPTURE_EN
        ,
        .i_capture(capture_in)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One access: strobes driven on a falling edge, sampled on the next rising edge,
    // response observed on the following falling edge.
    task automatic bus(input logic do_rd, input logic do_wr, input logic [2:0] idx,
                       input logic [31:0] wd, input logic [3:0] ws, output logic [31:0] rd);
        @(negedge clk);
        addr  = {27'd0, idx, 2'b00};
        rden  = do_rd;
        wren  = do_wr;
        wdata = wd;
        wstrb = ws;
        @(negedge clk);
        rden = 1'b0;
        wren = 1'b0;
        check("ready_pulse", {31'd0, ready}, 32'd1);
        rd = rdata;
    endtask

    task automatic wr(input logic [2:0] idx, input logic [31:0] wd, input logic [3:0] ws);
        logic [31:0] dummy;
        bus(1'b0, 1'b1, idx, wd, ws, dummy);
    endtask

    task automatic rd_chk(input string tag, input logic [2:0] idx, input logic [31:0] exp);
        logic [31:0] d;
        bus(1'b1, 1'b0, idx, '0, '0, d);
        check(tag, d, exp);
    endtask

    logic [2:0]  wrap_idx [6] = '{3'd2, 3'd2, 3'd4, 3'd2, 3'd4, 3'd2};
    logic [31:0] wrap_exp [6] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0, 32'h1, 32'h1, 32'h3};

    initial begin
        logic [31:0] d;
        rst   = 1'b1;
        addr  = '0;
        wren  = 1'b0;
        rden  = 1'b0;
        wdata = '0;
        wstrb = '0;
`ifdef PERI_TIMER_CAPTURE_EN
        capture_in = 1'b0;
`endif
        repeat (2) @(negedge clk);
        check("rst_ready", {31'd0, ready}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            rd_chk("reset_reg", 3'(i), (i == 3) ? 32'hFFFF_FFFF : 32'h0);
        end
        @(negedge clk);
        check("ready_idle", {31'd0, ready}, 32'd0);
        check("rdata_idle", rdata, 32'd0);

        // byte-masked COUNT write
        wr(3'd2, 32'h1234_5678, 4'b0101);
        rd_chk("count_bmask", 3'd2, 32'h0034_0078);
        rd_chk("count_bmask2", 3'd2, 32'h0034_0078);

        // simultaneous read+write on COMPARE returns the old value
        bus(1'b1, 1'b1, 3'd3, 32'h0000_00AA, 4'hF, d);
        check("rw_old", d, 32'hFFFF_FFFF);
        rd_chk("rw_new", 3'd3, 32'h0000_00AA);

        wr(3'd6, 32'hDEAD_BEEF, 4'hF);
        rd_chk("reserved6", 3'd6, 32'h0);
        wr(3'd0, 32'hFFFF_FFF8, 4'hF);
        rd_chk("ctrl_unused_bits", 3'd0, 32'h0);

        // prescaled counting with auto-reload
        wr(3'd1, 32'd3, 4'hF);
        rd_chk("prescale_rd", 3'd1, 32'd3);
        wr(3'd3, 32'd5, 4'hF);
        wr(3'd2, 32'd0, 4'hF);
        wr(3'd0, 32'd7, 4'hF);
        addr = 32'h8;
        rden = 1'b1;
        for (int k = 1; k <= 25; k++) begin
            @(negedge clk);
            check("run_ready", {31'd0, ready}, 32'd1);
            check("run_count", rdata, (k - 1 < 24) ? 32'((k - 1) / 4) : 32'd0);
            check("run_irq", {31'd0, irq}, (k >= 24) ? 32'd1 : 32'd0);
        end
        rden = 1'b0;
        wr(3'd4, 32'd1, 4'b1110);
        check("w1c_no_strobe", {31'd0, irq}, 32'd1);
        wr(3'd4, 32'd1, 4'b0001);
        check("w1c_irq_clear", {31'd0, irq}, 32'd0);
        wr(3'd0, 32'd0, 4'hF);
        rd_chk("status_cleared", 3'd4, 32'd0);

        // wrap through 0xFFFF_FFFF, match at COUNT==0
        wr(3'd1, 32'd0, 4'hF);
        wr(3'd3, 32'd0, 4'hF);
        wr(3'd2, 32'hFFFF_FFFE, 4'hF);
        wr(3'd0, 32'd1, 4'hF);
        rden = 1'b1;
        addr = {27'd0, wrap_idx[0], 2'b00};
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("wrap_seq", rdata, wrap_exp[k]);
            if (k < 5) addr = {27'd0, wrap_idx[k + 1], 2'b00};
            else rden = 1'b0;
        end
        wr(3'd0, 32'd0, 4'hF);

        // W1C colliding with a match tick: set wins
        wr(3'd3, 32'd10, 4'hF);
        wr(3'd2, 32'd5, 4'hF);
        wr(3'd4, 32'd1, 4'hF);
        rd_chk("status_pre", 3'd4, 32'd0);
        wr(3'd0, 32'd1, 4'hF);
        repeat (4) @(negedge clk);
        wr(3'd4, 32'd1, 4'hF);
        rd_chk("set_beats_w1c", 3'd4, 32'd1);
        wr(3'd0, 32'd5, 4'hF);
        check("irq_on", {31'd0, irq}, 32'd1);

        // asynchronous reset in the middle of an access
        @(negedge clk);
        addr = 32'h8;
        rden = 1'b1;
        @(posedge clk);
        #2;
        check("ready_before_rst", {31'd0, ready}, 32'd1);
        rst = 1'b1;
        #1;
        check("async_rst_ready", {31'd0, ready}, 32'd0);
        check("async_rst_rdata", rdata, 32'd0);
        check("async_rst_irq", {31'd0, irq}, 32'd0);
        rden = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        rd_chk("post_rst_ctrl", 3'd0, 32'd0);
        rd_chk("post_rst_count", 3'd2, 32'd0);
        rd_chk("post_rst_compare", 3'd3, 32'hFFFF_FFFF);
        rd_chk("post_rst_status", 3'd4, 32'd0);

`ifdef PERI_TIMER_CAPTURE_EN
        wr(3'd2, 32'd100, 4'hF);
        wr(3'd0, 32'd1, 4'hF);
        capture_in = 1'b1;
        repeat (4) @(negedge clk);
        capture_in = 1'b0;
        wr(3'd0, 32'd0, 4'hF);
        rd_chk("capture_val", 3'd5, 32'd102);
        rd_chk("capt_flag", 3'd4, 32'd2);
        wr(3'd4, 32'd2, 4'h1);
        rd_chk("capt_clear", 3'd4, 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
